// File: rtl/vedic_mul_arbiter.sv
// Round-robin front end sharing one fixed-latency pipelined multiplier between NUM_REQ requesters.
// Define VEDIC_ARB_PERF_EN to add the perf_issued / perf_conflict counters.
module vedic_mul_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MUL_LATENCY = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [2*WIDTH-1:0]       mul_p,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [2*WIDTH-1:0]       resp_product,
  output logic                     busy
`ifdef VEDIC_ARB_PERF_EN
  ,
  output logic [31:0]              perf_issued,
  output logic [31:0]              perf_conflict
`endif
);

  localparam int unsigned TagW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [TagW-1:0] tag_t;

  tag_t                     rr_ptr_q, rr_ptr_d;
  logic                     grant_vld;
  tag_t                     grant_idx;
  logic [WIDTH-1:0]         mul_a_q, mul_a_d;
  logic [WIDTH-1:0]         mul_b_q, mul_b_d;
  logic [MUL_LATENCY-1:0]   vld_q, vld_d;
  tag_t [MUL_LATENCY-1:0]   tag_q, tag_d;
  logic [NUM_REQ-1:0]       resp_valid_q, resp_valid_d;
  logic [2*WIDTH-1:0]       resp_product_q, resp_product_d;

  // Rotating priority search starting at rr_ptr; grant implies valid, so a grant is a transfer.
  always_comb begin
    int unsigned idx;
    tag_t        idx_t;
    idx       = 0;
    idx_t     = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx   = (32'(rr_ptr_q) + k) % NUM_REQ;
      idx_t = tag_t'(idx);
      if (!grant_vld && req_valid[idx_t]) begin
        grant_vld = 1'b1;
        grant_idx = idx_t;
      end
    end
    if (rst || hold) begin
      grant_vld = 1'b0;
    end
    req_ready = '0;
    if (grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == tag_t'(NUM_REQ - 1)) ? '0 : grant_idx + tag_t'(1);
      mul_a_d  = req_a[32'(grant_idx) * WIDTH +: WIDTH];
      mul_b_d  = req_b[32'(grant_idx) * WIDTH +: WIDTH];
    end
  end

  // Tag pipeline mirrors the multiplier depth; its last stage lines up with mul_p.
  always_comb begin
    vld_d    = '0;
    tag_d    = tag_q;
    vld_d[0] = grant_vld;
    tag_d[0] = grant_idx;
    for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    resp_valid_d   = '0;
    resp_product_d = resp_product_q;
    if (vld_q[MUL_LATENCY-1]) begin
      resp_valid_d[tag_q[MUL_LATENCY-1]] = 1'b1;
      resp_product_d                     = mul_p;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      vld_q          <= '0;
      tag_q          <= '0;
      resp_valid_q   <= '0;
      resp_product_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      vld_q          <= vld_d;
      tag_q          <= tag_d;
      resp_valid_q   <= resp_valid_d;
      resp_product_q <= resp_product_d;
    end
  end

  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign resp_valid   = resp_valid_q;
  assign resp_product = resp_product_q;
  assign busy         = (|vld_q) | (|resp_valid_q);

`ifdef VEDIC_ARB_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_conflict_q, perf_conflict_d;

  always_comb begin
    perf_issued_d   = perf_issued_q;
    perf_conflict_d = perf_conflict_q;
    if (grant_vld) begin
      perf_issued_d = perf_issued_q + 32'd1;
    end
    if (!hold && ($countones(req_valid) >= 2)) begin
      perf_conflict_d = perf_conflict_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued_q   <= '0;
      perf_conflict_q <= '0;
    end else begin
      perf_issued_q   <= perf_issued_d;
      perf_conflict_q <= perf_conflict_d;
    end
  end

  assign perf_issued   = perf_issued_q;
  assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// Scoreboard bench for vedic_mul_arbiter: a behavioural arbiter model queues expected responses,
// an independent monitor pops and compares them whenever the DUT strobes resp_valid.
module tb_vedic_mul_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             hold;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [2*W-1:0]   mul_p;
  logic [N-1:0]     resp_valid;
  logic [2*W-1:0]   resp_product;
  logic             busy;
`ifdef VEDIC_ARB_PERF_EN
  logic [31:0]      perf_issued;
  logic [31:0]      perf_conflict;
`endif

  vedic_mul_arbiter #(
    .NUM_REQ    (N),
    .WIDTH      (W),
    .MUL_LATENCY(L)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hold         (hold),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_p        (mul_p),
    .resp_valid   (resp_valid),
    .resp_product (resp_product),
    .busy         (busy)
`ifdef VEDIC_ARB_PERF_EN
    ,
    .perf_issued  (perf_issued),
    .perf_conflict(perf_conflict)
`endif
  );

  always #5 clk = ~clk;

  // Environment multiplier: product of the registered operands, L-1 further register stages.
  logic [2*W-1:0] mp_pipe [L-1];
  always @(posedge clk) begin
    mp_pipe[0] <= 64'(mul_a) * 64'(mul_b);
    for (int i = 1; i < L - 1; i++) mp_pipe[i] <= mp_pipe[i-1];
  end
  assign mul_p = mp_pipe[L-2];

  typedef struct {
    longint unsigned due;
    logic [N-1:0]    mask;
    logic [2*W-1:0]  prod;
  } exp_t;

  exp_t            sb[$];
  int unsigned     n_pass  = 0;
  int unsigned     n_total = 0;
  longint unsigned edge_cnt = 0;
  int              ptr = 0;
  logic [W-1:0]    op_a [N];
  logic [W-1:0]    op_b [N];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
  endtask

  // Reference arbiter: first valid index at or after the pointer, modulo N.
  function automatic int model_grant(input logic [N-1:0] v, input logic h, input logic r,
                                     input int p);
    if (r || h) return -1;
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic step(input logic [N-1:0] v, input logic h, input logic r);
    int           g;
    exp_t         e;
    logic [N-1:0] one;
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
    req_valid = v;
    hold      = h;
    rst       = r;
    #1;
    g   = model_grant(v, h, r, ptr);
    one = 1;
    check("req_ready", 64'(req_ready), (g >= 0) ? 64'(one << g) : 64'd0);
    if (r) begin
      sb.delete();
      ptr = 0;
    end else if (g >= 0) begin
      e.due  = edge_cnt + 1 + L;
      e.mask = one << g;
      e.prod = 64'(op_a[g]) * 64'(op_b[g]);
      sb.push_back(e);
      ptr = (g + 1) % N;
    end
  endtask

  // Monitor: decoupled from the driver, compares every presented response against the queue.
  always @(negedge clk) begin
    exp_t e;
    logic got;
    got = 1'b0;
    if (resp_valid !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 64'(resp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("resp_mask", 64'(resp_valid), 64'(e.mask));
        check("resp_product", resp_product, e.prod);
        check("resp_edge", 64'(edge_cnt), 64'(e.due));
        got = 1'b1;
      end
    end else if (sb.size() > 0 && sb[0].due <= edge_cnt) begin
      e = sb.pop_front();
      check("missing_resp", 64'd0, 64'(e.mask));
    end
    check("busy", 64'(busy), 64'((sb.size() > 0) || got));
  end

  initial begin
    int t;
    rst       = 1'b1;
    hold      = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end

    // Reset then idle
    repeat (3) step('1, 1'b0, 1'b1);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    check("rst_resp_product", resp_product, 64'd0);
    repeat (3) step('0, 1'b0, 1'b0);

    // Single op from requester 2
    op_a[2] = 32'hFFFF_FFFF;
    op_b[2] = 32'h2;
    step(4'b0100, 1'b0, 1'b0);
    repeat (8) step('0, 1'b0, 1'b0);
    check("single_product", resp_product, 64'h1_FFFF_FFFE);
    check("single_busy_low", 64'(busy), 64'd0);

    // Full contention: rotation 0,1,2,3,...
    step('0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) begin
      op_a[i] = 32'(i + 1);
      op_b[i] = 32'd10;
    end
    for (int k = 0; k < 8; k++) begin
      step('1, 1'b0, 1'b0);
      check("rotate_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
    end
    repeat (10) step('0, 1'b0, 1'b0);
`ifdef VEDIC_ARB_PERF_EN
    check("perf_issued", 64'(perf_issued), 64'd8);
    check("perf_conflict", 64'(perf_conflict), 64'd8);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);
    check("perf_issued_rst", 64'(perf_issued), 64'd0);
    check("perf_conflict_rst", 64'(perf_conflict), 64'd0);
`endif

    // Hold drain
    step('0, 1'b0, 1'b1);
    repeat (3) step('1, 1'b0, 1'b0);
    repeat (10) step('1, 1'b1, 1'b0);
    check("hold_drained", 64'(busy), 64'd0);
    step('1, 1'b0, 1'b0);
    check("hold_resume", 64'(req_ready), 64'(4'b1000));
    repeat (8) step('0, 1'b0, 1'b0);

    // Reset mid-flight discards in-flight ops and rewinds the pointer
    op_a[0] = 32'h1234_5678;
    repeat (4) step('1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    check("rst_busy", 64'(busy), 64'd0);
    step('1, 1'b0, 1'b0);
    check("rst_ptr_zero", 64'(req_ready), 64'(4'b0001));
    repeat (8) step('0, 1'b0, 1'b0);

    // Randomised traffic with sporadic hold and reset
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        op_a[i] = ($urandom % 4 == 0) ? '1 : $urandom;
        op_b[i] = ($urandom % 4 == 0) ? '1 : $urandom;
      end
      step(N'($urandom), ($urandom % 8) == 0, ($urandom % 60) == 0);
    end

    t = 0;
    while ((sb.size() > 0 || busy) && t < 20) begin
      step('0, 1'b0, 1'b0);
      t++;
    end
    check("drain_done", 64'({sb.size() != 0, busy}), 64'd0);
    step('0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
